// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle between the instruction prefetch queue, the instruction
// memory and the decode stage. The prefetch queue uses the master view.
interface instr_prefetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Instruction memory read port
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    // Branch/jump redirect from the execute stage
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    // Decode-side handshake
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc_inc;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect, redirect_pc,
        output id_valid,
        input  id_ready,
        output id_instr, id_pc_inc, q_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect, redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_instr, id_pc_inc, q_count
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues word reads to instruction memory,
// buffers returned words tagged with PC+4, and hands them to decode over a
// valid/ready handshake. Redirects flush the queue and drop in-flight data.
module instr_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 7,
    parameter logic [ADDR_W-1:0] PC_START = '0
) (
    input logic                    clk,
    input logic                    reset,
    instr_prefetch_queue_if.master bus
);
    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_OCC  = DEPTH[CNT_W:0];
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] START_PC   = {PC_START[ADDR_W-1:2], 2'b00};

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] tag_mem   [DEPTH];

    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_tag;
    logic              inflight;

    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              empty;
    logic              full;
    logic              issue;
    logic              push;
    logic              pop;

    // Queue status and the issue/push/pop decisions for this cycle
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every output a value first, so no latch can be inferred.
        count     = wr_ptr - rd_ptr;
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        // A word still in flight already owns a slot; a pop this cycle is not credited.
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue     = reset && !bus.redirect && (occupancy < DEPTH_OCC);
        // Responses landing during a redirect belong to the old path and are dropped.
        push      = inflight && !bus.redirect && !full;
        pop       = !empty && bus.id_ready && !bus.redirect;
    end

    // Fetch address, in-flight tracking and queue pointers
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            fetch_pc     <= START_PC;
            inflight     <= 1'b0;
            inflight_tag <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc     <= fetch_pc + WORD_BYTES;
                inflight_tag <= fetch_pc + WORD_BYTES;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Queue storage: returned word and its PC+4 tag
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the head is gated by id_valid, so stale contents never reach decode.
        if (push) begin
            instr_mem[wr_ptr[PTR_W-1:0]] <= bus.imem_rdata;
            tag_mem[wr_ptr[PTR_W-1:0]]   <= inflight_tag;
        end
    end

    // Memory request and decode-side outputs
    always_comb begin
        bus.imem_req  = issue;
        bus.imem_addr = fetch_pc;
        bus.id_valid  = !empty;
        bus.q_count   = count;
        bus.id_instr  = '0;
        bus.id_pc_inc = '0;
        if (!empty) begin
            bus.id_instr  = instr_mem[rd_ptr[PTR_W-1:0]];
            bus.id_pc_inc = tag_mem[rd_ptr[PTR_W-1:0]];
        end
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Testbench for instr_prefetch_queue: directed scenarios plus randomized
// stalls/redirects, checked by a scoreboard fed from a program-order model.
`timescale 1ns/1ps
module tb_instr_prefetch_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 7;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef struct {
        logic [31:0] instr;
        addr_t       pc_inc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    instr_prefetch_queue #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .PC_START(7'h00)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] mem_b [128];
    exp_t       exp_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    addr_t      exp_fetch;
    int         req_cnt = 0;
    int         pops    = 0;

    function automatic logic [31:0] word_at(addr_t a);
        int b;
        b = int'({a[ADDR_W-1:2], 2'b00});
        return {mem_b[b], mem_b[b+1], mem_b[b+2], mem_b[b+3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: word for a request is returned in the following cycle
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= word_at(bus.imem_addr);
    end

    // Expected decode stream after (re)starting fetch at a given address
    task automatic begin_stream(input addr_t start);
        addr_t a;
        a = {start[ADDR_W-1:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back('{instr: word_at(a), pc_inc: a + addr_t'(4)});
            a = a + addr_t'(4);
        end
    endtask

    // Monitor: fetch-address sequence, scoreboard on every accepted head, invariants
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            exp_fetch = '0;
            req_cnt   = 0;
        end else begin
            if (bus.redirect) begin
                check("redirect_req", 32'(bus.imem_req), 32'd0);
                exp_fetch = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            end else begin
                if (bus.imem_req) begin
                    check("fetch_addr", 32'(bus.imem_addr), 32'(exp_fetch));
                    exp_fetch = exp_fetch + addr_t'(4);
                    req_cnt++;
                end
                if (bus.id_valid && bus.id_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL scoreboard: pop of 0x%0h with no expected entry", bus.id_instr);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_instr", bus.id_instr, e.instr);
                        check("pop_pc_inc", 32'(bus.id_pc_inc), 32'(e.pc_inc));
                    end
                end
            end
            check("count_le_depth", 32'(bus.q_count <= DEPTH), 32'd1);
            check("valid_vs_count", 32'(bus.id_valid), 32'(bus.q_count != 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic reset_checks(input string p);
        check({p, "_req"},     32'(bus.imem_req),  32'd0);
        check({p, "_valid"},   32'(bus.id_valid),  32'd0);
        check({p, "_count"},   32'(bus.q_count),   32'd0);
        check({p, "_instr"},   bus.id_instr,       32'd0);
        check({p, "_pc_inc"},  32'(bus.id_pc_inc), 32'd0);
    endtask

    // Hold reset for two cycles and release it just after a rising edge (cycle 1 begins)
    task automatic do_reset(input logic rdy);
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready    = rdy;
        begin_stream('0);
        repeat (2) cyc();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            smp();
            if (bus.id_valid) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Reset-release timing: requests at cycles 1/2, first words visible at 3/4
    task automatic t1_checks(input string p);
        smp();
        check({p, "_c1_req"},   32'(bus.imem_req),  32'd1);
        check({p, "_c1_addr"},  32'(bus.imem_addr), 32'd0);
        check({p, "_c1_valid"}, 32'(bus.id_valid),  32'd0);
        cyc(); smp();
        check({p, "_c2_req"},   32'(bus.imem_req),  32'd1);
        check({p, "_c2_addr"},  32'(bus.imem_addr), 32'd4);
        check({p, "_c2_valid"}, 32'(bus.id_valid),  32'd0);
        cyc(); smp();
        check({p, "_c3_valid"}, 32'(bus.id_valid),  32'd1);
        check({p, "_c3_instr"}, bus.id_instr,       word_at(7'h00));
        check({p, "_c3_pcinc"}, 32'(bus.id_pc_inc), 32'd4);
        cyc(); smp();
        check({p, "_c4_instr"}, bus.id_instr,       word_at(7'h04));
        check({p, "_c4_pcinc"}, 32'(bus.id_pc_inc), 32'd8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int since;
        for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
        bus.id_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset state
        repeat (2) cyc();
        smp();
        reset_checks("rst");

        // T1: reset release with decode always ready
        do_reset(1'b1);
        t1_checks("t1");

        // T2: decode stalled, queue fills to DEPTH, single pop frees one slot
        do_reset(1'b0);
        repeat (8) cyc();
        smp();
        check("t2_count",   32'(bus.q_count),   32'd4);
        check("t2_req",     32'(bus.imem_req),  32'd0);
        check("t2_reqs",    32'(req_cnt),       32'd4);
        check("t2_instr",   bus.id_instr,       word_at(7'h00));
        check("t2_pcinc",   32'(bus.id_pc_inc), 32'd4);
        cyc();
        bus.id_ready = 1'b1;
        smp();
        check("t2_pop_req", 32'(bus.imem_req),  32'd0);
        cyc();
        bus.id_ready = 1'b0;
        smp();
        check("t2_count3",  32'(bus.q_count),   32'd3);
        check("t2_req16",   32'(bus.imem_req),  32'd1);
        check("t2_addr16",  32'(bus.imem_addr), 32'd16);

        // T3: redirect to 0x2B with 3 queued entries and one word in flight
        do_reset(1'b0);
        repeat (4) cyc();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 7'h2B;
        begin_stream(7'h2B);
        smp();
        check("t3_pre_count", 32'(bus.q_count),  32'd3);
        check("t3_redir_req", 32'(bus.imem_req), 32'd0);
        cyc();
        bus.redirect = 1'b0;
        bus.id_ready = 1'b1;
        smp();
        check("t3_count",  32'(bus.q_count),   32'd0);
        check("t3_valid",  32'(bus.id_valid),  32'd0);
        check("t3_req",    32'(bus.imem_req),  32'd1);
        check("t3_addr",   32'(bus.imem_addr), 32'h28);
        wait_valid("t3_wait_valid", 8);
        check("t3_pcinc",  32'(bus.id_pc_inc), 32'h2C);
        check("t3_instr",  bus.id_instr,       word_at(7'h28));

        // T4: fetch address wraps from 124 to 0
        do_reset(1'b1);
        cyc();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 7'h7C;
        begin_stream(7'h7C);
        cyc();
        bus.redirect = 1'b0;
        smp();
        check("t4_addr124", 32'(bus.imem_addr), 32'd124);
        cyc(); smp();
        check("t4_addr0",   32'(bus.imem_addr), 32'd0);
        check("t4_req0",    32'(bus.imem_req),  32'd1);
        cyc(); smp();
        check("t4_pcinc0",  32'(bus.id_pc_inc), 32'd0);
        check("t4_instr124", bus.id_instr,      word_at(7'h7C));
        cyc(); smp();
        check("t4_pcinc4",  32'(bus.id_pc_inc), 32'd4);
        check("t4_instr0",  bus.id_instr,       word_at(7'h00));

        // T5: back-to-back redirects, the last one wins
        do_reset(1'b1);
        repeat (3) cyc();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 7'h10;
        begin_stream(7'h10);
        cyc();
        bus.redirect_pc = 7'h40;
        begin_stream(7'h40);
        cyc();
        bus.redirect = 1'b0;
        smp();
        check("t5_addr", 32'(bus.imem_addr), 32'h40);
        wait_valid("t5_wait_valid", 8);
        check("t5_pcinc", 32'(bus.id_pc_inc), 32'h44);
        repeat (8) cyc();

        // T6: asynchronous reset with two entries queued, then T1 again
        do_reset(1'b0);
        repeat (3) cyc();
        smp();
        check("t6_pre_count", 32'(bus.q_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        reset_checks("t6_async");
        do_reset(1'b1);
        t1_checks("t6");

        // Randomized stalls and redirects
        do_reset(1'b1);
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            bus.id_ready = ($urandom_range(0, 99) < 65);
            if (since > 90 || $urandom_range(0, 99) < 6) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = addr_t'($urandom_range(0, 127));
                begin_stream(bus.redirect_pc);
                since = 0;
            end else begin
                bus.redirect = 1'b0;
                since++;
            end
        end
        cyc();
        bus.redirect = 1'b0;
        repeat (5) cyc();
        smp();
        check("pops_seen", 32'(pops > 500), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
